// File: rtl/fetch_aligner_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_aligner_pkg : shared FSM type and constants for the aligner  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package fetch_aligner_pkg;

  typedef enum logic [0:0] {
    F_IDLE = 1'b0,
    F_WAIT = 1'b1
  } fetch_state_e;

  // Low halfword bits that mark a full-width (32-bit) instruction.
  localparam logic [1:0]  c_INST32_LSB = 2'b11;
  localparam logic [31:0] c_PC_INC_C   = 32'd2;
  localparam logic [31:0] c_PC_INC_W   = 32'd4;

  function automatic logic is_compressed(input logic [15:0] hw);
    return hw[1:0] != c_INST32_LSB;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_aligner_hw_queue.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_aligner_hw_queue : 4x16 halfword shift queue, head at slot 0 |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module fetch_aligner_hw_queue (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flush_i,
  input  logic        pop1_i,
  input  logic        pop2_i,
  input  logic        push1_i,
  input  logic        push2_i,
  input  logic [15:0] push_d0_i,
  input  logic [15:0] push_d1_i,
  output logic [15:0] head0_o,
  output logic [15:0] head1_o,
  output logic [2:0]  count_o
);

  logic [3:0][15:0] ent_q, ent_d;
  logic [2:0]       count_q, count_d;
  logic [2:0]       w_base;
  logic [1:0]       w_pop_n, w_push_n;

  // Pop shifts the queue down first; pushed halfwords land after what remains.
  always_comb begin
    w_pop_n  = pop2_i  ? 2'd2 : {1'b0, pop1_i};
    w_push_n = push2_i ? 2'd2 : {1'b0, push1_i};
    w_base   = count_q - {1'b0, w_pop_n};
    ent_d    = ent_q >> {w_pop_n, 4'b0000};
    for (int i = 0; i < 4; i++) begin
      if (w_push_n != 2'd0 && w_base == 3'(i)) ent_d[i] = push_d0_i;
      if (w_push_n == 2'd2 && (w_base + 3'd1) == 3'(i)) ent_d[i] = push_d1_i;
    end
    count_d = w_base + {1'b0, w_push_n};
    if (flush_i) begin
      ent_d   = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ent_q   <= '0;
      count_q <= '0;
    end else begin
      ent_q   <= ent_d;
      count_q <= count_d;
    end
  end

  assign head0_o = ent_q[0];
  assign head1_o = ent_q[1];
  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/fetch_aligner.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_aligner : word fetch + halfword realignment into RV32/RVC    |
// | instructions. RVC_ALIGN_EN enables compressed handling.  Rev 1.0   |
// +--------------------------------------------------------------------+
module fetch_aligner
  import fetch_aligner_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_valid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_inst_o,
  output logic        out_is_c_o,
  output logic [31:0] out_pc_o
);

`ifdef RVC_ALIGN_EN
  localparam logic [31:0] c_START_PC = {RESET_PC[31:1], 1'b0};
`else
  localparam logic [31:0] c_START_PC = {RESET_PC[31:2], 2'b00};
`endif

  fetch_state_e state_q, state_d;
  logic [31:2]  fpc_q, fpc_d;
  logic [31:0]  opc_q, opc_d;
  logic         discard_q, discard_d;
  logic         req_q, req_d;

  logic [15:0]  w_h0, w_h1;
  logic [2:0]   w_count, w_cnt_after;
  logic         w_head_c, w_valid, w_xfer, w_pop1, w_pop2;
  logic         w_resp, w_skip;
  logic [31:0]  w_rpc;
  logic         w_unused_rpc;

`ifdef RVC_ALIGN_EN
  logic skip_q, skip_d;

  assign w_head_c     = is_compressed(w_h0);
  assign w_rpc        = {redirect_pc_i[31:1], 1'b0};
  assign w_unused_rpc = redirect_pc_i[0];
  assign w_skip       = skip_q;

  // An odd-halfword target drops the low half of the first word fetched.
  always_comb begin
    skip_d = skip_q;
    if (w_resp)     skip_d = 1'b0;
    if (redirect_i) skip_d = redirect_pc_i[1];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) skip_q <= c_START_PC[1];
    else         skip_q <= skip_d;
  end
`else
  assign w_head_c     = 1'b0;
  assign w_rpc        = {redirect_pc_i[31:2], 2'b00};
  assign w_unused_rpc = ^redirect_pc_i[1:0];
  assign w_skip       = 1'b0;
`endif

  assign w_valid     = (w_count >= 3'd1 && w_head_c) || (w_count >= 3'd2);
  assign w_xfer      = w_valid && out_ready_i && !redirect_i;
  assign w_pop1      = w_xfer && w_head_c;
  assign w_pop2      = w_xfer && !w_head_c;
  assign w_cnt_after = w_count - {1'b0, w_pop2, w_pop1};
  assign w_resp      = (state_q == F_WAIT) && imem_valid_i && !discard_q && !redirect_i;

  fetch_aligner_hw_queue u_hw_queue (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .flush_i   (redirect_i),
    .pop1_i    (w_pop1),
    .pop2_i    (w_pop2),
    .push1_i   (w_resp && w_skip),
    .push2_i   (w_resp && !w_skip),
    .push_d0_i (w_skip ? imem_rdata_i[31:16] : imem_rdata_i[15:0]),
    .push_d1_i (imem_rdata_i[31:16]),
    .head0_o   (w_h0),
    .head1_o   (w_h1),
    .count_o   (w_count)
  );

  always_comb begin
    state_d   = state_q;
    fpc_d     = fpc_q;
    opc_d     = opc_q;
    discard_d = discard_q;
    req_d     = 1'b0;
    if (w_xfer) opc_d = opc_q + (w_head_c ? c_PC_INC_C : c_PC_INC_W);
    case (state_q)
      F_IDLE: begin
        if (!redirect_i && w_cnt_after <= 3'd2) begin
          req_d   = 1'b1;
          state_d = F_WAIT;
        end
      end
      F_WAIT: begin
        // A response coinciding with a redirect is consumed and dropped here,
        // so discard only arms when the stale response is still in flight.
        if (imem_valid_i) begin
          state_d   = F_IDLE;
          discard_d = 1'b0;
          if (w_resp) fpc_d = fpc_q + 30'd1;
        end else if (redirect_i) begin
          discard_d = 1'b1;
        end
      end
      default: state_d = F_IDLE;
    endcase
    if (redirect_i) begin
      opc_d = w_rpc;
      fpc_d = w_rpc[31:2];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= F_IDLE;
      fpc_q     <= c_START_PC[31:2];
      opc_q     <= c_START_PC;
      discard_q <= 1'b0;
      req_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      fpc_q     <= fpc_d;
      opc_q     <= opc_d;
      discard_q <= discard_d;
      req_q     <= req_d;
    end
  end

  assign imem_req_o  = req_q;
  assign imem_addr_o = {fpc_q, 2'b00};
  assign out_valid_o = w_valid;
  assign out_inst_o  = w_head_c ? {16'h0000, w_h0} : {w_h1, w_h0};
  assign out_is_c_o  = w_valid && w_head_c;
  assign out_pc_o    = opc_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_aligner.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_fetch_aligner : scoreboard bench with a behavioural memory      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_fetch_aligner;

`ifdef RVC_ALIGN_EN
  localparam bit c_RVC = 1'b1;
`else
  localparam bit c_RVC = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] inst;
    logic        is_c;
    logic [31:0] pc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic        out_is_c;
  logic [31:0] out_pc;

  logic [31:0] mem [0:255];
  exp_t        sb[$];
  int          n_chk = 0;
  int          n_err = 0;
  int          mem_lat;
  bit          rand_lat, rand_ready, want_ready;

  always #5 clk = ~clk;

  fetch_aligner #(.RESET_PC(32'h0000_0000)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .imem_req_o    (imem_req),
    .imem_addr_o   (imem_addr),
    .imem_valid_i  (imem_valid),
    .imem_rdata_i  (imem_rdata),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .out_valid_o   (out_valid),
    .out_ready_i   (out_ready),
    .out_inst_o    (out_inst),
    .out_is_c_o    (out_is_c),
    .out_pc_o      (out_pc)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] half_at(input logic [31:0] a);
    logic [31:0] w;
    w = mem[a[9:2]];
    return a[1] ? w[31:16] : w[15:0];
  endfunction

  function automatic void push_exp(input logic [31:0] inst, input logic is_c, input logic [31:0] pc);
    exp_t e;
    e.inst = inst; e.is_c = is_c; e.pc = pc;
    sb.push_back(e);
  endfunction

  // Reference walk over the memory image, one instruction at a time.
  function automatic void push_stream(input logic [31:0] start, input int n);
    logic [31:0] pc;
    logic [15:0] h;
    pc = start;
    for (int k = 0; k < n; k++) begin
      h = half_at(pc);
      if (c_RVC && h[1:0] != 2'b11) begin
        push_exp({16'h0000, h}, 1'b1, pc);
        pc = pc + 32'd2;
      end else begin
        push_exp({half_at(pc + 32'd2), h}, 1'b0, pc);
        pc = pc + 32'd4;
      end
    end
  endfunction

  // Memory: one response per request, after a 1..3 cycle latency.
  int          wait_cnt;
  bit          pend;
  logic [31:0] pend_addr;
  initial begin
    imem_valid = 1'b0;
    imem_rdata = 32'h0;
    pend = 1'b0;
    wait_cnt = 0;
    pend_addr = 32'h0;
    forever begin
      @(negedge clk);
      imem_valid = 1'b0;
      if (!rst_n) begin
        pend = 1'b0;
      end else if (pend) begin
        if (wait_cnt == 0) begin
          imem_valid = 1'b1;
          imem_rdata = mem[pend_addr[9:2]];
          pend = 1'b0;
        end else begin
          wait_cnt--;
        end
      end
      if (rst_n && imem_req) begin
        pend = 1'b1;
        pend_addr = imem_addr;
        wait_cnt = rand_lat ? int'($urandom_range(0, 2)) : mem_lat - 1;
      end
    end
  end

  // Output monitor: every transfer is matched against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && !redirect && out_valid && out_ready) begin
        check_eq("sb_has_entry", {31'b0, sb.size() != 0}, 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check_eq("out_inst", out_inst, e.inst);
          check_eq("out_is_c", {31'b0, out_is_c}, {31'b0, e.is_c});
          check_eq("out_pc", out_pc, e.pc);
        end
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
    out_ready = (rand_ready ? ($urandom_range(0, 1) == 1) : want_ready) && (sb.size() != 0);
    @(negedge clk);
  endtask

  task automatic redirect_to(input logic [31:0] pc);
    @(posedge clk);
    #1;
    redirect = 1'b1;
    redirect_pc = pc;
    out_ready = 1'b0;
    sb.delete();
    @(posedge clk);
    #1;
    redirect = 1'b0;
    @(negedge clk);
    check_eq("valid_after_redirect", {31'b0, out_valid}, 32'd0);
  endtask

  task automatic drain(input int max_cyc);
    for (int k = 0; k < max_cyc && sb.size() != 0; k++) cycle();
    check_eq("drain_left", 32'(sb.size()), 32'd0);
  endtask

  task automatic wait_req(input int max_cyc, output logic [31:0] addr);
    bit seen;
    seen = 1'b0;
    addr = 32'hFFFF_FFFF;
    for (int k = 0; k < max_cyc && !seen; k++) begin
      cycle();
      if (imem_req) begin
        seen = 1'b1;
        addr = imem_addr;
      end
    end
    check_eq("req_seen", {31'b0, seen}, 32'd1);
  endtask

  task automatic push_word_pair_exp();
    if (c_RVC) begin
      push_exp(32'h0000_4501, 1'b1, 32'h0);
      push_exp(32'h0010_0513, 1'b0, 32'h2);
    end else begin
      push_exp(32'h0513_4501, 1'b0, 32'h0);
      push_exp(32'h0000_0010, 1'b0, 32'h4);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    int          reqs;
    rst_n = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; out_ready = 1'b0;
    want_ready = 1'b0; rand_ready = 1'b0; rand_lat = 1'b0; mem_lat = 1;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[0] = 32'h0001_4501;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_req",   {31'b0, imem_req},  32'd0);
    check_eq("rst_addr",  imem_addr,          32'h0);
    check_eq("rst_valid", {31'b0, out_valid}, 32'd0);
    check_eq("rst_inst",  out_inst,           32'h0);
    check_eq("rst_is_c",  {31'b0, out_is_c},  32'd0);
    check_eq("rst_pc",    out_pc,             32'h0);

    // Single word holding two compressed instructions (or one 32-bit).
    if (c_RVC) begin
      push_exp(32'h0000_4501, 1'b1, 32'h0);
      push_exp(32'h0000_0001, 1'b1, 32'h2);
    end else begin
      push_exp(32'h0001_4501, 1'b0, 32'h0);
    end
    want_ready = 1'b1;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    cycle();
    check_eq("first_req",  {31'b0, imem_req}, 32'd1);
    check_eq("first_addr", imem_addr,         32'h0);
    drain(50);

    // 32-bit instruction split across two words.
    mem[0] = 32'h0513_4501;
    mem[1] = 32'h0000_0010;
    redirect_to(32'h0);
    push_word_pair_exp();
    drain(50);

    // Redirect to an odd halfword while a fetch is still outstanding.
    mem[8'h10] = 32'hDEAD_BEEF;
    mem[8'h41] = 32'h1234_5678;
    mem[8'h42] = 32'hABCD_0001;
    mem_lat = 3;
    redirect_to(32'h40);
    wait_req(20, a);
    check_eq("pre_redirect_addr", a, 32'h40);
    redirect_to(32'h106);
    if (c_RVC) begin
      push_exp(32'h0000_1234, 1'b1, 32'h106);
      push_exp(32'h0000_0001, 1'b1, 32'h108);
      push_exp(32'h0000_ABCD, 1'b1, 32'h10A);
    end else begin
      push_exp(32'h1234_5678, 1'b0, 32'h104);
      push_exp(32'hABCD_0001, 1'b0, 32'h108);
    end
    wait_req(20, a);
    check_eq("redirect_addr", a, 32'h104);
    drain(60);
    mem_lat = 1;

    // Decode stalls: queue fills to four halfwords and fetching stops.
    for (int i = 0; i < 16; i++)
      mem[128 + i] = {16'h4001 + 16'((2 * i + 1) << 4), 16'h4001 + 16'((2 * i) << 4)};
    want_ready = 1'b0;
    redirect_to(32'h200);
    push_stream(32'h200, 8);
    reqs = 0;
    repeat (10) begin
      cycle();
      if (imem_req) reqs++;
    end
    check_eq("stall_reqs",  32'(reqs),          32'd2);
    check_eq("stall_valid", {31'b0, out_valid}, 32'd1);
    want_ready = 1'b1;
    drain(100);

    // Random instruction mix with random latency and backpressure.
    for (int i = 192; i < 224; i++) mem[i] = $urandom;
    rand_lat = 1'b1;
    rand_ready = 1'b1;
    redirect_to(32'h302);
    push_stream(c_RVC ? 32'h302 : 32'h300, 20);
    drain(600);
    rand_ready = 1'b0;
    rand_lat = 1'b0;

    // Asynchronous reset in the middle of a stream.
    want_ready = 1'b1;
    redirect_to(32'h0);
    push_word_pair_exp();
    repeat (5) cycle();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_req",   {31'b0, imem_req},  32'd0);
    check_eq("arst_addr",  imem_addr,          32'h0);
    check_eq("arst_valid", {31'b0, out_valid}, 32'd0);
    check_eq("arst_inst",  out_inst,           32'h0);
    check_eq("arst_is_c",  {31'b0, out_is_c},  32'd0);
    check_eq("arst_pc",    out_pc,             32'h0);
    sb.delete();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    push_word_pair_exp();
    cycle();
    check_eq("rearm_req",  {31'b0, imem_req}, 32'd1);
    check_eq("rearm_addr", imem_addr,         32'h0);
    drain(50);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
